// File: rtl/lif_neuron_array.sv
// Array of independent leaky integrate-and-fire neurons sharing one threshold,
// with refractory handling, a registered potential readout port and a
// saturating population spike counter.
module lif_neuron_array #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACT    = 2
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               step,
    input  logic [N_NEURONS*WIDTH-1:0]                         current,
    input  logic [WIDTH-1:0]                                   threshold,
    input  logic                                               sub_mode,
    input  logic                                               clear_count,
    input  logic [(N_NEURONS > 1 ? $clog2(N_NEURONS) : 1)-1:0] sel,
    output logic [N_NEURONS-1:0]                               spike,
    output logic [WIDTH-1:0]                                   potential,
    output logic [15:0]                                        spike_count
);

    localparam int RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int CNT_W = $clog2(N_NEURONS + 1);

    logic [WIDTH-1:0]     u_q  [N_NEURONS];
    logic [WIDTH-1:0]     u_d  [N_NEURONS];
    logic [RC_W-1:0]      rc_q [N_NEURONS];
    logic [RC_W-1:0]      rc_d [N_NEURONS];
    logic [N_NEURONS-1:0] fire_d;
    logic [CNT_W-1:0]     n_fire;
    logic [16:0]          count_sum;
    logic [15:0]          count_d;
    logic [WIDTH-1:0]     sel_u;

    // Per-neuron timestep update: leak, integrate, saturate, fire and refractory bookkeeping
    always_comb begin
        logic [WIDTH-1:0] leaked;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] sat;
        leaked = '0;
        sum    = '0;
        sat    = '0;
        fire_d = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            u_d[i]  = u_q[i];
            rc_d[i] = rc_q[i];
            leaked  = u_q[i] - (u_q[i] >> LEAK_SHIFT);
            sum     = {1'b0, leaked} + {1'b0, current[i*WIDTH +: WIDTH]};
            sat     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            if (step) begin
                if (rc_q[i] != '0) begin
                    rc_d[i] = rc_q[i] - RC_W'(1);
                    u_d[i]  = leaked;
                end else if (threshold != '0 && sat >= threshold) begin
                    fire_d[i] = 1'b1;
                    u_d[i]    = sub_mode ? (sat - threshold) : '0;
                    rc_d[i]   = RC_W'(REFRACT);
                end else begin
                    u_d[i] = sat;
                end
            end
        end
    end

    // Population count of this step's spikes and saturating accumulation
    always_comb begin
        n_fire = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            n_fire = n_fire + CNT_W'(fire_d[i]);
        end
        count_sum = {1'b0, spike_count} + 17'(n_fire);
        count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Readout mux for the selected neuron; out-of-range indices read as zero
    always_comb begin
        sel_u = '0;
        if (int'(sel) < N_NEURONS) begin
            sel_u = u_q[sel];
        end
    end

    // State registers; clear_count outranks the spikes counted in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                u_q[i]  <= '0;
                rc_q[i] <= '0;
            end
            spike       <= '0;
            potential   <= '0;
            spike_count <= '0;
        end else begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                u_q[i]  <= u_d[i];
                rc_q[i] <= rc_d[i];
            end
            spike       <= fire_d;
            potential   <= sel_u;
            spike_count <= clear_count ? '0 : count_d;
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array with default parameters
// (4 neurons, 8-bit, leak >>2, 2 refractory steps).
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic        sub_mode;
    logic        clear_count;
    logic [1:0]  sel;
    logic [3:0]  spike;
    logic [7:0]  potential;
    logic [15:0] spike_count;

    int n_assert = 0;
    int n_fail   = 0;

    lif_neuron_array #(
        .N_NEURONS (4),
        .WIDTH     (8),
        .LEAK_SHIFT(2),
        .REFRACT   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .current    (current),
        .threshold  (threshold),
        .sub_mode   (sub_mode),
        .clear_count(clear_count),
        .sel        (sel),
        .spike      (spike),
        .potential  (potential),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle step strobe; returns at the negedge after the step edge
    task automatic do_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        step        = 1'b0;
        current     = '0;
        threshold   = 8'd100;
        sub_mode    = 1'b0;
        clear_count = 1'b0;
        sel         = 2'd0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("reset_spike", 32'(spike), 32'h0);
        check("reset_potential", 32'(potential), 32'h0);
        check("reset_count", 32'(spike_count), 32'h0);

        // Integrate and reset-to-zero firing on neuron 0; neuron 1 integrates 10/step
        current = {8'd0, 8'd0, 8'd10, 8'd40};
        do_step();
        check("int_s1_spike", 32'(spike), 32'h0);
        @(negedge clk);
        check("int_s1_u0", 32'(potential), 32'd40);
        @(negedge clk);
        check("int_hold_u0", 32'(potential), 32'd40);
        check("int_hold_spike", 32'(spike), 32'h0);
        do_step();
        @(negedge clk);
        check("int_s2_u0", 32'(potential), 32'd70);
        do_step();
        @(negedge clk);
        check("int_s3_u0", 32'(potential), 32'd93);
        do_step();
        check("int_s4_spike", 32'(spike), 32'h1);
        check("int_s4_count", 32'(spike_count), 32'd1);
        @(negedge clk);
        check("int_s4_spike_gone", 32'(spike), 32'h0);
        check("int_s4_u0", 32'(potential), 32'd0);
        sel = 2'd1;
        @(negedge clk);
        @(negedge clk);
        check("int_u1", 32'(potential), 32'd28);
        sel = 2'd0;

        // Subtract mode and refractory leak-only steps
        do_reset();
        sub_mode = 1'b1;
        repeat (3) do_step();
        do_step();
        check("sub_s4_spike", 32'(spike), 32'h1);
        @(negedge clk);
        check("sub_s4_u0", 32'(potential), 32'd10);
        do_step();
        check("sub_r1_spike", 32'(spike), 32'h0);
        @(negedge clk);
        check("sub_r1_u0", 32'(potential), 32'd8);
        do_step();
        @(negedge clk);
        check("sub_r2_u0", 32'(potential), 32'd6);
        do_step();
        check("sub_s7_spike", 32'(spike), 32'h0);
        @(negedge clk);
        check("sub_s7_u0", 32'(potential), 32'd45);
        check("sub_count", 32'(spike_count), 32'd1);

        // Saturation with firing disabled
        do_reset();
        sub_mode  = 1'b0;
        threshold = 8'd0;
        current   = {8'd0, 8'd0, 8'd0, 8'd200};
        do_step();
        @(negedge clk);
        check("sat_u0_200", 32'(potential), 32'd200);
        current = {8'd0, 8'd0, 8'd0, 8'd255};
        do_step();
        check("sat_spike", 32'(spike), 32'h0);
        @(negedge clk);
        check("sat_u0", 32'(potential), 32'd255);
        check("sat_count", 32'(spike_count), 32'd0);

        // Simultaneous firing with clear_count priority
        do_reset();
        threshold   = 8'd100;
        current     = {4{8'd255}};
        clear_count = 1'b1;
        do_step();
        clear_count = 1'b0;
        check("sim_clr_spike", 32'(spike), 32'hF);
        check("sim_clr_count", 32'(spike_count), 32'd0);
        do_step();
        check("sim_refr_spike", 32'(spike), 32'h0);
        do_step();
        do_step();
        check("sim_spike", 32'(spike), 32'hF);
        check("sim_count", 32'(spike_count), 32'd4);

        // Count saturation: back-to-back steps, all four fire every third step
        do_reset();
        step = 1'b1;
        repeat (49149) @(negedge clk);
        step = 1'b0;
        check("cnt_fffc", 32'(spike_count), 32'hFFFC);
        current = {8'd0, 8'd0, 8'd255, 8'd255};
        do_step();
        check("cnt_two_spike", 32'(spike), 32'h3);
        check("cnt_fffe", 32'(spike_count), 32'hFFFE);
        do_step();
        do_step();
        check("cnt_refr_hold", 32'(spike_count), 32'hFFFE);
        current = {4{8'd255}};
        do_step();
        check("cnt_sat_spike", 32'(spike), 32'hF);
        check("cnt_ffff", 32'(spike_count), 32'hFFFF);

        // Reset during a step while neurons are refractory
        reset = 1'b1;
        step  = 1'b1;
        @(negedge clk);
        check("rst_step_spike", 32'(spike), 32'h0);
        check("rst_step_potential", 32'(potential), 32'h0);
        check("rst_step_count", 32'(spike_count), 32'h0);
        reset   = 1'b0;
        step    = 1'b0;
        current = {8'd0, 8'd0, 8'd0, 8'd40};
        do_step();
        @(negedge clk);
        check("rst_no_refr_u0", 32'(potential), 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of independent leaky integrate-and-fire neurons (1..16).
REQ-002 SHALL have parameter WIDTH, default 8: membrane-potential, current and threshold width in bits, unsigned.
REQ-003 SHALL have parameter LEAK_SHIFT, default 2: leak per step is u >> LEAK_SHIFT.
REQ-004 SHALL have parameter REFRACT, default 2: refractory steps after a spike (0 disables refractoriness).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port step  input  1  one-cycle strobe; each high cycle advances every neuron by one timestep.
REQ-008 SHALL have port current  input  N_NEURONS*WIDTH  per-neuron input current; neuron i uses bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port threshold  input  WIDTH  shared firing threshold; 0 means firing disabled.
REQ-010 SHALL have port sub_mode  input  1  on spike: 1 = subtract threshold from potential, 0 = reset potential to 0.
REQ-011 SHALL have port clear_count  input  1  synchronous clear of spike_count.
REQ-012 SHALL have port sel  input  clog2(N_NEURONS) (min 1)  neuron index for potential readout.
REQ-013 SHALL have port spike  output  N_NEURONS  registered spike flags.
REQ-014 SHALL have port potential  output  WIDTH  registered membrane potential of neuron sel.
REQ-015 SHALL have port spike_count  output  16  saturating total spike count across all neurons.

Function
REQ-016 SHALL, on a step cycle for neuron i not refractory: u_next = u - (u >> LEAK_SHIFT) + current_i, computed at WIDTH+1 bits, saturated to 2^WIDTH-1.
REQ-017 SHALL fire neuron i when threshold != 0 and u_next >= threshold; spike[i] high for exactly the one cycle after the step cycle.
REQ-018 SHALL, on firing, store u_next - threshold if sub_mode=1, else 0; sub_mode/threshold sampled in the step cycle.
REQ-019 SHALL, on firing, load neuron i's refractory counter with REFRACT.
REQ-020 SHALL, on a step cycle with refractory counter > 0, decrement counter, apply leak only (ignore current), never fire.
REQ-021 SHALL, when step=0, hold all potentials and counters and drive spike=0.
REQ-022 SHALL add popcount(spike fires this step) to spike_count, saturating at 16'hFFFF.
REQ-023 SHALL give clear_count priority: when clear_count=1, spike_count becomes 0 and spikes of that same step are not counted.
REQ-024 SHALL update potential one cycle after sel or the selected neuron's state changes (one-cycle registered readout).
REQ-025 SHALL evaluate all neurons in parallel in the same step cycle; no inter-neuron coupling.
REQ-026 SHALL treat back-to-back step cycles as consecutive timesteps with no lost update.

Reset
REQ-027 SHALL, while reset=1 at a clk edge, clear all potentials, refractory counters, spike, potential and spike_count to 0; reset overrides step and clear_count.
REQ-028 SHALL, on reset mid-refractory, leave neurons non-refractory from the first post-reset step.

Verification
REQ-029 Integrate: N=4, WIDTH=8, LEAK_SHIFT=2, REFRACT=2, threshold=100, sub_mode=0, current0=40, four steps -> u0 = 40, 70, 93, then spike[0]=1 one cycle after step 4, u0=0, spike_count=1.
REQ-030 Subtract mode: same as REQ-029 with sub_mode=1 -> after step 4 u0=10; next two steps leak only (10->8->6), no spike; third step integrates (6-1+40=45).
REQ-031 Saturation: u0=200, current0=255, threshold=0 -> u0=255, no spike, spike_count unchanged.
REQ-032 Simultaneous: all four neurons fire in one step with clear_count=1 -> spike=4'b1111, spike_count=0; next identical firing step without clear -> spike_count=4.
REQ-033 Count saturation and reset: preload spike_count to 16'hFFFE, fire 4 neurons -> 16'hFFFF; assert reset during a step -> all outputs 0 next cycle, step ignored.
